// File: rtl/seq_shifter.sv
// seq_shifter: serial shifter, one bit position per clock, with a start/busy/done handshake
module seq_shifter #(
    parameter int W  = 8,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  din,
    input  logic [SW-1:0] shamt,
    input  logic          LorR,
    input  logic          AorL,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  dout
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  sreg_q, sreg_d, dout_q, dout_d, step;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          lr_q, lr_d, al_q, al_d, busy_q, busy_d, done_q, done_d;

    // one-bit step; right shifts fill with the sign bit only in arithmetic mode
    always_comb step = lr_q ? {sreg_q[W-2:0], 1'b0} : {al_q & sreg_q[W-1], sreg_q[W-1:1]};

    // next state: accept in IDLE, shift until the count runs out, then a single DONE cycle
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        lr_d    = lr_q;
        al_d    = al_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: if (start) begin
                sreg_d  = din;
                cnt_d   = shamt;
                lr_d    = LorR;
                al_d    = AorL;
                state_d = (shamt == '0) ? DONE : SHIFT;
                dout_d  = (shamt == '0) ? din : dout_q;
            end
            SHIFT: begin
                sreg_d = step;
                cnt_d  = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    state_d = DONE;
                    dout_d  = step;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    // all state and outputs registered; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            lr_q    <= 1'b0;
            al_q    <= 1'b0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            lr_q    <= lr_d;
            al_q    <= al_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: scenario tasks checking seq_shifter against a barrel-shift model
module tb_seq_shifter;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, LorR = 1'b0, AorL = 1'b0;
    logic [7:0] din = '0;
    logic [2:0] shamt = '0;
    logic       busy, done;
    logic [7:0] dout;
    int vectors = 0, errs = 0;

    seq_shifter #(.W(8), .SW(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .shamt(shamt),
        .LorR(LorR), .AorL(AorL), .busy(busy), .done(done), .dout(dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [7:0] d, input int n, input logic lr, input logic al);
        logic signed [7:0] s;
        s = d;
        s = s >>> n;
        if (lr) return d << n;
        if (al) return s;
        return d >> n;
    endfunction

    task automatic run_op(input logic [7:0] d, input logic [2:0] n, input logic lr, input logic al, input bit scramble);
        logic [7:0] exp;
        int k;
        exp = model(d, n, lr, al);
        @(negedge clk);
        start = 1'b1; din = d; shamt = n; LorR = lr; AorL = al;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (scramble) begin
            din = 8'($urandom); shamt = 3'($urandom); LorR = 1'($urandom); AorL = 1'($urandom);
        end
        vectors++;
        if (busy !== 1'b1) begin errs++; $display("FAIL op_busy: got %b want 1", busy); end
        k = 0;
        @(negedge clk);
        while (done !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        vectors++;
        if (k !== int'(n)) begin errs++; $display("FAIL op_latency d=%h n=%0d lr=%b al=%b: got %0d want %0d", d, n, lr, al, k, n); end
        vectors++;
        if (dout !== exp) begin errs++; $display("FAIL op_dout d=%h n=%0d lr=%b al=%b: got %h want %h", d, n, lr, al, dout, exp); end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || dout !== exp) begin
            errs++; $display("FAIL op_after: got done=%b busy=%b dout=%h want 0 0 %h", done, busy, dout, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'($urandom); din = 8'($urandom); shamt = 3'($urandom); LorR = 1'($urandom); AorL = 1'($urandom);
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0 || dout !== 8'h00) begin
                errs++; $display("FAIL reset_hold: got busy=%b done=%b dout=%h want 0 0 00", busy, done, dout);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || dout !== 8'h00) begin
            errs++; $display("FAIL reset_idle: got busy=%b done=%b dout=%h want 0 0 00", busy, done, dout);
        end
    endtask

    task automatic test_directed();
        run_op(8'h96, 3'd3, 1'b0, 1'b1, 1'b0);
        run_op(8'h96, 3'd3, 1'b0, 1'b0, 1'b0);
        run_op(8'h96, 3'd3, 1'b1, 1'b1, 1'b0);
        run_op(8'h96, 3'd0, 1'b0, 1'b0, 1'b0);
        run_op(8'h80, 3'd7, 1'b0, 1'b1, 1'b0);
        run_op(8'h80, 3'd7, 1'b0, 1'b0, 1'b0);
        run_op(8'h01, 3'd7, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_abuse();
        int k, dones;
        @(negedge clk);
        start = 1'b1; din = 8'h96; shamt = 3'd5; LorR = 1'b0; AorL = 1'b0;
        @(negedge clk);
        start = 1'b0; din = 8'hFF; shamt = 3'd1; LorR = 1'b1;
        @(negedge clk);
        start = 1'b1; din = 8'h3C; shamt = 3'd0;
        @(negedge clk);
        start = 1'b0;
        k = 2; dones = 0;
        while (done !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        vectors++;
        if (k !== 5) begin errs++; $display("FAIL abuse_latency: got %0d want 5", k); end
        vectors++;
        if (dout !== 8'h04) begin errs++; $display("FAIL abuse_dout: got %h want 04", dout); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0 || busy !== 1'b0) begin errs++; $display("FAIL abuse_extra_done: got dones=%0d busy=%b want 0 0", dones, busy); end
    endtask

    task automatic test_back_to_back();
        int t[$];
        logic prev;
        int bad_dout, consec;
        prev = 1'b0; bad_dout = 0; consec = 0;
        @(negedge clk);
        start = 1'b1; din = 8'h96; shamt = 3'd2; LorR = 1'b1; AorL = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                t.push_back(c);
                if (dout !== 8'h58) bad_dout++;
                if (prev) consec++;
            end
            prev = done;
        end
        start = 1'b0;
        vectors++;
        if (t.size() < 4) begin
            errs++; $display("FAIL b2b_count: got %0d dones want >=4", t.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (t[i] - t[i-1] !== 4) begin errs++; $display("FAIL b2b_interval: got %0d want 4", t[i] - t[i-1]); end
            end
        end
        vectors++;
        if (bad_dout !== 0 || consec !== 0) begin errs++; $display("FAIL b2b_dout: got bad=%0d consec=%0d want 0 0", bad_dout, consec); end
        for (int i = 0; i < 20 && busy === 1'b1; i++) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin errs++; $display("FAIL b2b_drain: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        @(negedge clk);
        start = 1'b1; din = 8'hA5; shamt = 3'd5; LorR = 1'b0; AorL = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || dout !== 8'h00) begin
            errs++; $display("FAIL rstmid_clear: got busy=%b done=%b dout=%h want 0 0 00", busy, done, dout);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0) begin errs++; $display("FAIL rstmid_no_done: got %0d want 0", dones); end
        run_op(8'hA5, 3'd5, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++)
            run_op(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abuse();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
